// File: rtl/usb_ep_status_pkg.sv
// Shared definitions for the USB endpoint status RAM aux-port sequencer.
// Address/data widths are fixed by the status RAM geometry.
package usb_ep_status_pkg;

  localparam int unsigned EPS_AW     = 8;
  localparam int unsigned EPS_DW     = 16;
  localparam int unsigned EPS_RD_LAT = 3;

  // Value loaded into the WAIT countdown at the read grant; the response
  // fires when it reaches 1, i.e. EPS_RD_LAT cycles after the grant.
  localparam logic [1:0] EPS_WAIT_LOAD = 2'(EPS_RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_INIT  = 2'd3
  } eps_state_e;

endpackage : usb_ep_status_pkg

// File: rtl/usb_ep_status_ctrl_if.sv
// Request/response bus between the CPU bridge (master) and the
// endpoint status sequencer (slave).
interface usb_ep_status_ctrl_if;
  import usb_ep_status_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [EPS_AW-1:0] req_addr;
  logic [EPS_DW-1:0] req_wdata;
  logic              rsp_valid;
  logic [EPS_DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface : usb_ep_status_ctrl_if

// File: rtl/usb_ep_status_ctrl.sv
// Sequencer between a request/response bus and the aux R/W port of the
// USB endpoint status RAM. Retries while the priority port holds the RAM,
// tracks the fixed read latency and returns one response per request.
// Optional post-reset zero-fill sweep: define USB_EP_STATUS_INIT_EN.
module usb_ep_status_ctrl
  import usb_ep_status_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  usb_ep_status_ctrl_if.slave bus,
  output logic [EPS_AW-1:0] s_addr_0,
  output logic              s_read_0,
  output logic              s_zero_0,
  output logic              s_write_0,
  output logic [EPS_DW-1:0] s_din_0,
  input  logic [EPS_DW-1:0] s_dout_3,
  input  logic              s_ready_0,
  output logic              init_busy
);

  eps_state_e        state_q;
  logic [1:0]        lat_cnt_q;
  logic              rsp_valid_q;
  logic              s_read_q;
  logic              s_write_q;
  logic [EPS_AW-1:0] s_addr_q;
  logic [EPS_DW-1:0] s_din_q;

`ifdef USB_EP_STATUS_INIT_EN
  logic [EPS_AW-1:0] init_cnt_q;
  logic              init_busy_q;
`endif

  // Main sequencer: accept, issue with retry, read-latency countdown, init sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef USB_EP_STATUS_INIT_EN
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
`else
      state_q     <= S_IDLE;
`endif
      lat_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
      s_addr_q    <= '0;
      s_din_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            s_addr_q  <= bus.req_addr;
            s_din_q   <= bus.req_wdata;
            s_write_q <= bus.req_write;
            s_read_q  <= ~bus.req_write;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (s_ready_0) begin
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            if (s_write_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              lat_cnt_q <= EPS_WAIT_LOAD;
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == 2'd1) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end
        S_INIT: begin
`ifdef USB_EP_STATUS_INIT_EN
          if (s_ready_0) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
              init_busy_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = s_dout_3;
  assign s_read_0      = s_read_q;
  assign s_zero_0      = 1'b0;

`ifdef USB_EP_STATUS_INIT_EN
  // The sweep write is driven straight from init_busy_q so the first grant can
  // land in the first cycle after reset; masking with rst keeps the aux
  // request low while reset is still held.
  assign s_write_0 = s_write_q | (init_busy_q & ~rst);
  assign s_addr_0  = init_busy_q ? init_cnt_q : s_addr_q;
  assign s_din_0   = init_busy_q ? '0 : s_din_q;
  assign init_busy = init_busy_q;
`else
  assign s_write_0 = s_write_q;
  assign s_addr_0  = s_addr_q;
  assign s_din_0   = s_din_q;
  assign init_busy = 1'b0;
`endif

endmodule : usb_ep_status_ctrl

// File: tb/tb_usb_ep_status_ctrl.sv
// Directed self-checking bench for usb_ep_status_ctrl with a behavioural
// status RAM (3-cycle aux read latency) and a priority-port driver.
module tb_usb_ep_status_ctrl;
  import usb_ep_status_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_addr_0;
  logic        s_read_0, s_zero_0, s_write_0, s_ready_0, init_busy;
  logic [15:0] s_din_0, s_dout_3;

  logic        prio_busy, prio_we, fill_all;
  logic [7:0]  prio_addr;
  logic [15:0] prio_data, fill_val;

  logic [15:0] mem [256];
  logic [15:0] pipe1, pipe2;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int excl_err = 0;

  usb_ep_status_ctrl_if bus ();

  usb_ep_status_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .s_addr_0  (s_addr_0),
    .s_read_0  (s_read_0),
    .s_zero_0  (s_zero_0),
    .s_write_0 (s_write_0),
    .s_din_0   (s_din_0),
    .s_dout_3  (s_dout_3),
    .s_ready_0 (s_ready_0),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign s_ready_0 = ~prio_busy;

  // Status RAM model: priority port wins; aux read data appears 3 cycles after grant
  always @(posedge clk) begin
    if (fill_all) begin
      for (int i = 0; i < 256; i++) mem[i] <= fill_val;
    end else begin
      if (prio_busy && prio_we) mem[prio_addr] <= prio_data;
      if (s_ready_0 && s_write_0) mem[s_addr_0] <= s_din_0;
    end
    pipe1    <= (s_ready_0 && s_read_0) ? mem[s_addr_0] : 16'hDEAD;
    pipe2    <= pipe1;
    s_dout_3 <= pipe2;
  end

  always @(negedge clk) if (s_read_0 && s_write_0) excl_err++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b0;
    for (int n = 0; n < 2000 && !bus.req_ready; n++) tick();
    if (!bus.req_ready) to = 1'b1;
  endtask

  task automatic prio_write(input logic [7:0] a, input logic [15:0] d);
    prio_busy = 1'b1; prio_we = 1'b1; prio_addr = a; prio_data = d;
    tick();
    prio_busy = 1'b0; prio_we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [15:0] d, output bit to);
    bit t;
    bit got;
    wait_idle(t);
    to = t;
    got = 1'b0;
    d = 'x;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a;
    tick();
    bus.req_valid = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.rsp_valid) begin d = bus.rsp_rdata; got = 1'b1; end
      else tick();
    end
    if (!got) to = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    bit to;
    rst = 1'b1;
    tick(); tick();
    total++; if (s_read_0 !== 1'b0) begin bad++; $display("FAIL reset_s_read got=%0h exp=0", s_read_0); end
    total++; if (s_write_0 !== 1'b0) begin bad++; $display("FAIL reset_s_write got=%0h exp=0", s_write_0); end
    total++; if (s_addr_0 !== 8'h00) begin bad++; $display("FAIL reset_s_addr got=%0h exp=0", s_addr_0); end
    total++; if (s_din_0 !== 16'h0000) begin bad++; $display("FAIL reset_s_din got=%0h exp=0", s_din_0); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
    total++; if (s_zero_0 !== 1'b0) begin bad++; $display("FAIL reset_s_zero got=%0h exp=0", s_zero_0); end
`ifdef USB_EP_STATUS_INIT_EN
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%0h exp=0", bus.req_ready); end
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL reset_init_busy got=%0h exp=1", init_busy); end
`else
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0h exp=1", bus.req_ready); end
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL reset_init_busy got=%0h exp=0", init_busy); end
`endif
    rst = 1'b0;
    wait_idle(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL reset_idle_timeout got=%0h exp=0", to); end
  endtask

  task automatic test_read_uncontended;
    int r, rd_cnt, rd_at, rsp_cnt, rsp_at;
    logic [15:0] data;
    rd_cnt = 0; rd_at = -1; rsp_cnt = 0; rsp_at = -1; data = 'x;
    prio_write(8'h12, 16'hBEEF);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h12; bus.req_wdata = 16'h0000;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rd_req_ready got=%0h exp=1", bus.req_ready); end
    r = cyc;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (s_read_0) begin rd_cnt++; rd_at = cyc - r; end
      if (bus.rsp_valid) begin rsp_cnt++; rsp_at = cyc - r; data = bus.rsp_rdata; end
      tick();
    end
    total++; if (rd_cnt !== 1) begin bad++; $display("FAIL rd_s_read_cycles got=%0d exp=1", rd_cnt); end
    total++; if (rd_at !== 1) begin bad++; $display("FAIL rd_s_read_at got=R+%0d exp=R+1", rd_at); end
    total++; if (rsp_cnt !== 1) begin bad++; $display("FAIL rd_rsp_count got=%0d exp=1", rsp_cnt); end
    total++; if (rsp_at !== 4) begin bad++; $display("FAIL rd_rsp_at got=R+%0d exp=R+4", rsp_at); end
    total++; if (data !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", data); end
  endtask

  task automatic test_write_contended;
    int r, wr_cnt, unstable, rsp_cnt, rsp_at;
    logic [15:0] data;
    bit to;
    wr_cnt = 0; unstable = 0; rsp_cnt = 0; rsp_at = -1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h40; bus.req_wdata = 16'h1234;
    r = cyc;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      prio_busy = (k <= 5); prio_we = (k <= 5); prio_addr = 8'h41; prio_data = 16'h5555;
      if (s_write_0) begin
        wr_cnt++;
        if (s_addr_0 !== 8'h40 || s_din_0 !== 16'h1234 || s_read_0 !== 1'b0) unstable++;
      end
      if (bus.rsp_valid) begin rsp_cnt++; rsp_at = cyc - r; end
      tick();
    end
    prio_busy = 1'b0; prio_we = 1'b0;
    total++; if (wr_cnt !== 6) begin bad++; $display("FAIL wr_s_write_cycles got=%0d exp=6", wr_cnt); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL wr_hold_stable got=%0d exp=0", unstable); end
    total++; if (rsp_cnt !== 1) begin bad++; $display("FAIL wr_rsp_count got=%0d exp=1", rsp_cnt); end
    total++; if (rsp_at !== 7) begin bad++; $display("FAIL wr_rsp_at got=R+%0d exp=R+7", rsp_at); end
    do_read(8'h40, data, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL wr_readback_timeout got=%0h exp=0", to); end
    total++; if (data !== 16'h1234) begin bad++; $display("FAIL wr_readback got=%h exp=1234", data); end
    do_read(8'h41, data, to);
    total++; if (data !== 16'h5555) begin bad++; $display("FAIL wr_prio_data got=%h exp=5555", data); end
  endtask

  task automatic test_back_to_back;
    int r, rsp_cnt, rsp_at;
    logic [15:0] data;
    rsp_cnt = 0; rsp_at = -1; data = 'x;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h01; bus.req_wdata = 16'hA5A5;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%0h exp=1", bus.req_ready); end
    r = cyc;
    tick();
    bus.req_write = 1'b0;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_issue_ready got=%0h exp=0", bus.req_ready); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_wr_rsp got=%0h exp=1", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_second_ready got=%0h exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    total++; if (s_read_0 !== 1'b1 || s_addr_0 !== 8'h01) begin bad++; $display("FAIL b2b_read_issue got=%0h/%h exp=1/01", s_read_0, s_addr_0); end
    for (int k = 3; k <= 9; k++) begin
      if (bus.rsp_valid) begin rsp_cnt++; rsp_at = cyc - r; data = bus.rsp_rdata; end
      tick();
    end
    total++; if (rsp_cnt !== 1 || rsp_at !== 6) begin bad++; $display("FAIL b2b_rd_rsp got=%0d@R+%0d exp=1@R+6", rsp_cnt, rsp_at); end
    total++; if (data !== 16'hA5A5) begin bad++; $display("FAIL b2b_rd_data got=%h exp=a5a5", data); end
  endtask

  task automatic test_reset_mid_wait;
    int rsp_cnt;
    logic [15:0] data;
    bit to;
    rsp_cnt = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h12;
    tick();
    bus.req_valid = 1'b0;
    tick();
    total++; if (s_read_0 !== 1'b0) begin bad++; $display("FAIL rstw_wait_no_read got=%0h exp=0", s_read_0); end
    rst = 1'b1;
    #1;
    total++; if (s_addr_0 !== 8'h00) begin bad++; $display("FAIL rstw_s_addr got=%h exp=00", s_addr_0); end
    total++; if (s_read_0 !== 1'b0 || s_write_0 !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstw_ctrl got=%0h%0h%0h exp=000", s_read_0, s_write_0, bus.rsp_valid); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.rsp_valid) rsp_cnt++;
      tick();
    end
    total++; if (rsp_cnt !== 0) begin bad++; $display("FAIL rstw_no_rsp got=%0d exp=0", rsp_cnt); end
    do_read(8'h12, data, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rstw_next_timeout got=%0h exp=0", to); end
`ifdef USB_EP_STATUS_INIT_EN
    total++; if (data !== 16'h0000) begin bad++; $display("FAIL rstw_next_data got=%h exp=0000", data); end
`else
    total++; if (data !== 16'hBEEF) begin bad++; $display("FAIL rstw_next_data got=%h exp=beef", data); end
`endif
  endtask

`ifdef USB_EP_STATUS_INIT_EN
  task automatic run_sweep(input bit contend, output int busy, output int nwr,
                           output int rr_err, output int seq_err);
    busy = 0; nwr = 0; rr_err = 0; seq_err = 0;
    rst = 1'b1; fill_val = 16'hFFFF; fill_all = 1'b1;
    tick();
    fill_all = 1'b0;
    tick();
    rst = 1'b0;
    while (init_busy && busy < 2000) begin
      prio_busy = contend && (busy % 2 == 0);
      prio_we = 1'b0;
      if (bus.req_ready) rr_err++;
      if (s_write_0 && s_ready_0) begin
        if (s_addr_0 !== 8'(nwr) || s_din_0 !== 16'h0000) seq_err++;
        nwr++;
      end
      busy++;
      tick();
    end
    prio_busy = 1'b0;
  endtask

  task automatic test_init_sweep;
    int busy, nwr, rr_err, seq_err;
    logic [15:0] data;
    bit to;
    run_sweep(1'b0, busy, nwr, rr_err, seq_err);
    total++; if (busy !== 256) begin bad++; $display("FAIL init_busy_cycles got=%0d exp=256", busy); end
    total++; if (nwr !== 256 || seq_err !== 0) begin bad++; $display("FAIL init_sweep got=%0d/%0d exp=256/0", nwr, seq_err); end
    total++; if (rr_err !== 0) begin bad++; $display("FAIL init_req_ready got=%0d exp=0", rr_err); end
    do_read(8'h00, data, to);
    total++; if (data !== 16'h0000 || to) begin bad++; $display("FAIL init_rd00 got=%h exp=0000", data); end
    do_read(8'h7F, data, to);
    total++; if (data !== 16'h0000 || to) begin bad++; $display("FAIL init_rd7f got=%h exp=0000", data); end
    do_read(8'hFF, data, to);
    total++; if (data !== 16'h0000 || to) begin bad++; $display("FAIL init_rdff got=%h exp=0000", data); end
  endtask

  task automatic test_init_contended;
    int busy, nwr, rr_err, seq_err;
    logic [15:0] data;
    bit to;
    run_sweep(1'b1, busy, nwr, rr_err, seq_err);
    total++; if (busy !== 512) begin bad++; $display("FAIL initc_busy_cycles got=%0d exp=512", busy); end
    total++; if (nwr !== 256 || seq_err !== 0) begin bad++; $display("FAIL initc_sweep got=%0d/%0d exp=256/0", nwr, seq_err); end
    total++; if (rr_err !== 0) begin bad++; $display("FAIL initc_req_ready got=%0d exp=0", rr_err); end
    do_read(8'h80, data, to);
    total++; if (data !== 16'h0000 || to) begin bad++; $display("FAIL initc_rd80 got=%h exp=0000", data); end
  endtask
`endif

  task automatic test_exclusive;
    total++; if (excl_err !== 0) begin bad++; $display("FAIL rd_wr_exclusive got=%0d exp=0", excl_err); end
  endtask

  initial begin
    rst = 1'b1;
    prio_busy = 1'b0; prio_we = 1'b0; prio_addr = '0; prio_data = '0;
    fill_all = 1'b0; fill_val = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_read_uncontended();
    test_write_contended();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef USB_EP_STATUS_INIT_EN
    test_init_sweep();
    test_init_contended();
`endif
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_usb_ep_status_ctrl

// File: doc/usb_ep_status_ctrl.md
Name: usb_ep_status_ctrl

Overview:
- Sequencer between a simple request/response bus (CPU/wishbone bridge side) and the aux R/W port of the USB endpoint status RAM.
- Handles the aux-port grant handshake: retries while the priority (USB core) port holds the RAM.
- Tracks the fixed 3-cycle read latency and returns one response per request.
- Optionally zero-fills all 256 status entries after reset.

Parameters:
- none. Address is 8 b and data is 16 b, both fixed by the status RAM.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  status entry address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse, request complete
- rsp_rdata  out  16  read data, valid when rsp_valid on a read; wired to s_dout_3
- s_addr_0  out  8  aux port address
- s_read_0  out  1  aux read request
- s_zero_0  out  1  aux zero-read request; tied 0
- s_write_0  out  1  aux write request
- s_din_0  out  16  aux write data
- s_dout_3  in  16  aux read data, 3 cycles after grant
- s_ready_0  in  1  aux grant (low while priority port active)
- init_busy  out  1  init sweep in progress

Behaviour:
- Reset (async, rst=1) sets the following:
  - state = INIT if USB_EP_STATUS_INIT_EN is defined, else IDLE
  - s_read_0 = 0, s_write_0 = 0, s_addr_0 = 0, s_din_0 = 0
  - rsp_valid = 0, init counter = 0
- States:
  - INIT: see Optional Feature.
  - IDLE: req_ready = 1. On req_valid, latch addr, wdata and write into registers, then go to ISSUE. No other state asserts req_ready.
  - ISSUE: drive s_addr_0 and s_din_0 from the latched values. Assert s_write_0 (write) or s_read_0 (read). Hold all of these unchanged until a cycle A where s_ready_0 = 1; that cycle is the grant.
    - Write granted: next state IDLE; rsp_valid pulses in A+1.
    - Read granted: next state WAIT, with a 2-bit counter loaded.
  - WAIT: no aux request is driven. rsp_valid pulses in cycle A+3, when s_dout_3 holds the data; the state is IDLE in that same cycle.
- Latency with no contention, request accept cycle R:
  - ISSUE in R+1.
  - Write response in R+2.
  - Read response in R+4.
  - Next accept possible in the response cycle.
- Contention: each cycle with s_ready_0 = 0 in ISSUE adds one cycle. There is no timeout; the priority port can stall indefinitely.
- s_read_0 and s_write_0 are never both 1. Neither is asserted outside ISSUE or INIT.
- rsp_rdata is not held stable after the response cycle; consumers must capture it on rsp_valid.
- Reset mid-operation: the in-flight request is dropped with no rsp_valid. A write already granted may still land in RAM.
- req_valid in a non-IDLE state is ignored. The requester must hold req_valid until accepted.

Optional Feature:
- Macro: USB_EP_STATUS_INIT_EN
- Defined:
  - After reset, state INIT with init_busy = 1.
  - Drive s_write_0 = 1, s_din_0 = 0, s_addr_0 = counter.
  - The counter increments on each grant.
  - After the grant at address 0xFF, go to IDLE and set init_busy = 0.
  - Minimum duration is 256 cycles; stalls extend it.
  - req_ready = 0 throughout.
- Undefined:
  - No INIT state; init_busy is tied 0.
  - IDLE immediately after reset.

Decomposition:
- Shared package usb_ep_status_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, INIT)
  - EPS_RD_LAT = 3
  - EPS_AW = 8, EPS_DW = 16
- Single module; no sub-module is warranted.
- The bench instantiates it with usb_ep_status plus a priority-port driver.

Test Plan:
- Uncontended read of addr 0x12 preloaded with 0xBEEF, accepted at cycle R -> s_read_0 high exactly in R+1; rsp_valid only in R+4 with rsp_rdata = 0xBEEF.
- Write 0x1234 to addr 0x40 with the priority port writing continuously for 5 cycles -> s_write_0 held 6 cycles, addr/data stable throughout; rsp_valid 1 cycle after grant; a later read returns 0x1234.
- Back-to-back: write 0xA5A5 to addr 0x01 with req_valid held high, then read addr 0x01 -> second accept in the write-response cycle; read returns 0xA5A5.
- Reset asserted during WAIT of a read -> outputs zero immediately; no rsp_valid; next request completes normally.
- INIT_EN, all RAM preloaded 0xFFFF, no contention -> init_busy high exactly 256 cycles, req_ready 0 during that time; reads of 0x00, 0x7F and 0xFF return 0x0000.
- INIT_EN with priority port active every other cycle -> the sweep still covers all 256 addresses exactly once, in order, in 512 cycles.
